// File: rtl/pmem_burst_responder.sv
// Purpose : turns one 256-bit pmem line read/write into a command plus a BEAT_W-wide beat burst.
// Latency : zero-wait transaction completes (pmem_resp) BEATS+2 cycles after the request is sampled.
// Backpr. : burst_cmd_ready / burst_wready stalls hold the command or beat stable; reads are not backpressured.
//
// Ports
//   clk, rst_n                   : rising-edge clock, async active-low reset
//   pmem_read/write/address/wdata: line request from the cache side (held until pmem_resp)
//   pmem_resp, pmem_rdata        : one-cycle completion pulse, read line (held until next read completes)
//   burst_cmd_*                  : valid/ready command channel (line-aligned address, write flag)
//   burst_w*                     : valid/ready write beat channel, beat 0 first
//   burst_r*                     : read beat channel, no backpressure
//
// Optional feature: define PMEM_LINE_BUFFER_EN to keep the last completed read line; a read hitting it
// completes in one cycle without a burst, and a write to that line refreshes it.

module pmem_burst_responder #(
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [255:0]      pmem_wdata,
  output logic              pmem_resp,
  output logic [255:0]      pmem_rdata,
  output logic              burst_cmd_valid,
  input  logic              burst_cmd_ready,
  output logic              burst_cmd_write,
  output logic [31:0]       burst_cmd_addr,
  output logic              burst_wvalid,
  input  logic              burst_wready,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic              burst_rvalid,
  input  logic [BEAT_W-1:0] burst_rdata
);

  localparam int BEATS = 256 / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [31:0]      addr_q;
  logic             wr_q;
  logic [255:0]     wline_q;
  logic [255:0]     rline_q;
  logic [255:0]     rline_nxt;
  logic [7:0]       beat_lsb;
  logic             last_beat;
  logic             rd_hit;

  assign beat_lsb  = 8'(beat_cnt) * 8'(BEAT_W);
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // Line being assembled with the current read beat merged in; used both to
  // update the assembly register and to publish the finished line in one step.
  always_comb begin
    rline_nxt = rline_q;
    rline_nxt[beat_lsb +: BEAT_W] = burst_rdata;
  end

  // All outputs are state decodes or registers; nothing combinational from pmem_*.
  assign burst_cmd_valid = (state == CMD);
  assign burst_wvalid    = (state == WDATA);
  assign pmem_resp       = (state == RESP);
  assign burst_cmd_write = wr_q;
  assign burst_cmd_addr  = addr_q;
  assign burst_wdata     = (state == WDATA) ? wline_q[beat_lsb +: BEAT_W] : '0;

`ifdef PMEM_LINE_BUFFER_EN
  logic         buf_vld;
  logic [26:0]  buf_tag;
  logic [255:0] buf_line;

  assign rd_hit = buf_vld && (buf_tag == pmem_address[31:5]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_line <= '0;
    end else begin
      if (state == RDATA && burst_rvalid && last_beat) begin
        buf_vld  <= 1'b1;
        buf_tag  <= addr_q[31:5];
        buf_line <= rline_nxt;
      end
      // Keep the buffered copy coherent with a completed write to the same line.
      if (state == WDATA && burst_wready && last_beat && buf_vld && buf_tag == addr_q[31:5]) begin
        buf_line <= wline_q;
      end
    end
  end
`else
  assign rd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wline_q    <= '0;
      rline_q    <= '0;
      pmem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both requests are raised together.
          if (pmem_write) begin
            addr_q  <= pmem_address & LINE_MASK;
            wr_q    <= 1'b1;
            wline_q <= pmem_wdata;
            state   <= CMD;
          end else if (pmem_read) begin
            addr_q <= pmem_address & LINE_MASK;
            wr_q   <= 1'b0;
`ifdef PMEM_LINE_BUFFER_EN
            if (rd_hit) begin
              pmem_rdata <= buf_line;
              state      <= RESP;
            end else begin
              state <= CMD;
            end
`else
            state <= CMD;
`endif
          end
        end
        CMD: begin
          if (burst_cmd_ready) begin
            beat_cnt <= '0;
            state    <= wr_q ? WDATA : RDATA;
          end
        end
        WDATA: begin
          if (burst_wready) begin
            // Counter parks on the last beat; only CMD returns it to zero.
            if (last_beat) state <= RESP;
            else           beat_cnt <= beat_cnt + 1'b1;
          end
        end
        RDATA: begin
          if (burst_rvalid) begin
            rline_q <= rline_nxt;
            if (last_beat) begin
              pmem_rdata <= rline_nxt;
              state      <= RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
module tb_pmem_burst_responder;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 256 / BEAT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pmem_read = 1'b0;
  logic              pmem_write = 1'b0;
  logic [31:0]       pmem_address = '0;
  logic [255:0]      pmem_wdata = '0;
  logic              pmem_resp;
  logic [255:0]      pmem_rdata;
  logic              burst_cmd_valid;
  logic              burst_cmd_ready = 1'b0;
  logic              burst_cmd_write;
  logic [31:0]       burst_cmd_addr;
  logic              burst_wvalid;
  logic              burst_wready = 1'b0;
  logic [BEAT_W-1:0] burst_wdata;
  logic              burst_rvalid = 1'b0;
  logic [BEAT_W-1:0] burst_rdata = '0;

  pmem_burst_responder #(.BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .burst_cmd_valid(burst_cmd_valid), .burst_cmd_ready(burst_cmd_ready),
    .burst_cmd_write(burst_cmd_write), .burst_cmd_addr(burst_cmd_addr),
    .burst_wvalid(burst_wvalid), .burst_wready(burst_wready), .burst_wdata(burst_wdata),
    .burst_rvalid(burst_rvalid), .burst_rdata(burst_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: backing memory per line, last-read-line buffer, last read result.
  logic [255:0] mem [logic [26:0]];
  bit           bvalid = 0;
  logic [26:0]  btag = '0;
  logic [255:0] last_rd = '0;
  logic [26:0]  t;
  logic [255:0] l;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One pmem transaction; mode 0 zero-wait, 1 random stalls, 2 wready alternating,
  // 3 cmd_ready low for the first 10 cycles. Request is presented in cycle 0.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wl, input int mode);
    int           c, s, k;
    bit           cmd_done, done, hit, rdy;
    logic [26:0]  tg;
    logic [255:0] exp_line;
    tg = addr[31:5];
    if (!wr && !mem.exists(tg)) mem[tg] = rand_line();
    hit = 0;
`ifdef PMEM_LINE_BUFFER_EN
    hit = !wr && bvalid && (btag == tg);
`endif
    exp_line     = wr ? wl : mem[tg];
    pmem_write   = wr;
    pmem_read    = !wr || ($urandom % 2 == 1);
    pmem_address = addr;
    pmem_wdata   = wl;
    c = 0; s = 0; k = 0; cmd_done = 0; done = 0;
    while (!done && c < 300) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      burst_cmd_ready = 1'b0;
      burst_wready    = 1'b0;
      burst_rvalid    = 1'b0;
      burst_rdata     = BEAT_W'({$urandom, $urandom});
      if (pmem_resp) begin
        done = 1;
        check("resp_latency", c, hit ? 1 : BEATS + 2 + s);
        if (!wr) check("read_line", pmem_rdata, exp_line);
        else     check("rdata_hold", pmem_rdata, last_rd);
      end else if (burst_cmd_valid) begin
        if (hit) check("hit_no_cmd", burst_cmd_valid, 1'b0);
        check("cmd_addr", burst_cmd_addr, addr & 32'hFFFF_FFE0);
        check("cmd_write", burst_cmd_write, wr);
        rdy = (mode == 3) ? (c > 10) : (mode == 1) ? ($urandom % 3 != 0) : 1'b1;
        burst_cmd_ready = rdy;
        if (rdy) cmd_done = 1; else s++;
        if (!wr) burst_rvalid = ($urandom % 2 == 1);  // ignored outside RDATA
      end else if (cmd_done && wr) begin
        if (k < BEATS) begin
          check("wvalid", burst_wvalid, 1'b1);
          check("wdata_beat", burst_wdata, wl[k*BEAT_W +: BEAT_W]);
          rdy = (mode == 2) ? (c % 2 == 0) : (mode == 1) ? ($urandom % 3 != 0) : 1'b1;
          burst_wready = rdy;
          if (rdy) k++; else s++;
          burst_rvalid = ($urandom % 2 == 1);  // ignored outside RDATA
        end else begin
          check("extra_wvalid", burst_wvalid, 1'b0);
        end
      end else if (cmd_done && !wr) begin
        check("no_wvalid_on_read", burst_wvalid, 1'b0);
        if (k < BEATS) begin
          rdy = (mode == 1) ? ($urandom % 3 != 0) : 1'b1;
          if (rdy) begin
            burst_rvalid = 1'b1;
            burst_rdata  = exp_line[k*BEAT_W +: BEAT_W];
            k++;
          end else begin
            s++;
          end
        end
      end
    end
    if (!done) check("resp_timeout", 1'b0, 1'b1);
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    burst_cmd_ready = 1'b0;
    burst_wready    = 1'b0;
    burst_rvalid    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("resp_single_pulse", pmem_resp, 1'b0);
    if (wr) begin
      mem[tg] = wl;
    end else begin
      last_rd = exp_line;
      bvalid  = 1;
      btag    = tg;
    end
  endtask

  initial begin
    #1;
    check("rst_resp", pmem_resp, 1'b0);
    check("rst_rdata", pmem_rdata, '0);
    check("rst_cmd_valid", burst_cmd_valid, 1'b0);
    check("rst_cmd_addr", burst_cmd_addr, '0);
    check("rst_wvalid", burst_wvalid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read 0x1234, beats carry their own index.
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = BEAT_W'(k);
    mem[27'h91] = l;
    run_txn(0, 32'h0000_1234, '0, 0);

    // Write with alternating wready, then read it back.
    run_txn(1, 32'h0000_2040, rand_line(), 2);
    run_txn(0, 32'h0000_2040, '0, 0);

    // Command stalled 10 cycles.
    run_txn(0, 32'h0000_3000, '0, 3);

    // Spurious read beats while idle.
    burst_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      burst_rdata = BEAT_W'({$urandom, $urandom});
      @(negedge clk);
      check("idle_rdata_stable", pmem_rdata, last_rd);
      check("idle_no_resp", pmem_resp, 1'b0);
    end
    burst_rvalid = 1'b0;

    // Reset after two read beats.
    t = 27'h77;
    mem[t] = rand_line();
    pmem_read = 1'b1;
    pmem_address = {t, 5'h3};
    @(negedge clk);
    check("rst_mid_cmd", burst_cmd_valid, 1'b1);
    burst_cmd_ready = 1'b1;
    @(negedge clk);
    burst_cmd_ready = 1'b0;
    burst_rvalid = 1'b1;
    burst_rdata = BEAT_W'({$urandom, $urandom});
    @(negedge clk);
    burst_rdata = BEAT_W'({$urandom, $urandom});
    @(negedge clk);
    burst_rvalid = 1'b0;
    pmem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_resp", pmem_resp, 1'b0);
    check("midrst_rdata", pmem_rdata, '0);
    check("midrst_cmd_valid", burst_cmd_valid, 1'b0);
    check("midrst_cmd_write", burst_cmd_write, 1'b0);
    check("midrst_cmd_addr", burst_cmd_addr, '0);
    check("midrst_wvalid", burst_wvalid, 1'b0);
    check("midrst_wdata", burst_wdata, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bvalid = 0;
    last_rd = '0;
    @(negedge clk);
    mem[t] = rand_line();
    run_txn(0, {t, 5'h0}, '0, 0);

    // Line-buffer sequence (plain misses when the buffer is not built in).
    run_txn(0, 32'h0000_0100, '0, 0);
    run_txn(0, 32'h0000_011C, '0, 0);
    run_txn(1, 32'h0000_0104, rand_line(), 0);
    run_txn(0, 32'h0000_0100, '0, 0);

    // Randomized mix over a few lines so buffer hits and overwrites occur.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'h4000_0000 + 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 31));
      if ($urandom % 2 == 1) run_txn(1, a, rand_line(), 1);
      else                   run_txn(0, a, '0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
